shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Control stage placed directly upstream of the team's 4-bit universal shift register.
- Accepts a command (word, direction, shift count, fill bit) on a valid/ready handshake.
- Drives the register's mode selects, parallel inputs and serial inputs to parallel-load the word and then shift it N times.
- Captures the register's parallel output and reports it with a one-cycle done pulse.

Parameters:
- WIDTH, 4, register width; fixed to match the downstream register.
- MAX_SHIFT, 4, largest shift count honoured; larger requests are clamped.
- CNT_W, 3, width of cmd_count and the internal shift counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- clear  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_word  in  WIDTH  word to parallel-load
- cmd_dir  in  1  0 = shift right (toward A0), 1 = shift left (toward A3)
- cmd_count  in  CNT_W  number of shifts, 0..7; values above MAX_SHIFT are clamped
- cmd_fill  in  1  serial bit entering on each shift
- reg_q  in  WIDTH  feedback of register outputs {A3,A2,A1,A0}
- S0, S1  out  1 each  register mode select
- par_out  out  WIDTH  to register I3..I0
- shift_right  out  1  register MSB serial input
- shift_left  out  1  register LSB serial input
- busy  out  1  command in progress
- done  out  1  one-cycle pulse; result is valid
- result  out  WIDTH  captured register value

Behaviour:
- Mode encoding {S0,S1}: 00 hold, 01 shift right (shift_right enters A3), 10 shift left (shift_left enters A0), 11 parallel load.
- Reset (clear low, immediate, no clock needed):
  - State goes to IDLE.
  - S0=S1=0, par_out=0, shift_right=shift_left=0.
  - done=0, result=0, busy=0; cmd_ready=1 once clear is high.
- States:
  - IDLE: cmd_ready=1, selects 00. Acceptance is cmd_valid&&cmd_ready at an edge. On acceptance, latch word, dir, fill and min(count,MAX_SHIFT), then go to LOAD.
  - LOAD: selects 11, par_out = latched word. Next state is SHIFT if count>0, otherwise CAPTURE.
  - SHIFT: selects 01 (dir=0) or 10 (dir=1). The fill bit is driven on shift_right (dir=0) or shift_left (dir=1); the unused serial input is 0. Counter decrements each edge; after the edge where it reaches 0, go to CAPTURE.
  - CAPTURE: selects 00. At the edge, result<=reg_q and done<=1, then go to IDLE.
- par_out, shift_right and shift_left are held at 0 outside LOAD and SHIFT.
- busy=1 in LOAD, SHIFT and CAPTURE.
- Latency: done is high in the cycle following edge E0+count+2, where E0 is the acceptance edge and count is after clamping.
- done lasts exactly one cycle. result holds until the next capture or reset.
- A new command may be accepted in the same cycle done is high, giving back-to-back operation with no idle gap.
- cmd_* inputs are ignored while busy. Latched values are unaffected by input changes mid-operation.
- Reset mid-operation aborts the command: no done pulse, result returns to 0.
- No arithmetic beyond the counter decrement; the counter never underflows.

Decomposition:
- Shared package holds:
  - Mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11, as {S0,S1}.
  - State encoding ST_IDLE, ST_LOAD, ST_SHIFT, ST_CAPTURE.
  - MAX_SHIFT.
- Single module; no sub-module is needed.
- The bench instantiates the sequencer together with the existing 4-bit shift register, closing the loop through reg_q.

Test Plan:
- Right shifts: word=1010, dir=0, count=2, fill=1 → register 1010, 1101, 1110; done 4 edges after acceptance; result=1110.
- Left shifts: word=1011, dir=1, count=3, fill=0 → register 0110, 1100, 1000; result=1000; done 5 edges after acceptance.
- Zero count: word=0101, count=0 → no SHIFT cycles; result=0101; done 2 edges after acceptance.
- Clamp: word=0000, dir=0, count=7, fill=1 → exactly 4 shifts; result=1111; done at edge E0+6.
- Mid-operation reset: clear low during the second SHIFT cycle → all outputs immediately 0, state IDLE, no done. After release, a new command completes normally.
- Back-to-back: second command presented with cmd_valid held → accepted in the done cycle of the first. Both results correct; cmd_ready low throughout busy.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: sizes, register mode codes,
// FSM state encoding, latched command payload and the shift-count clamp.
package shift_sequencer_pkg;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned MAX_SHIFT = 4;

    // Register mode selects, packed as {S0,S1}
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    // Command fields held for the duration of one operation
    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             dir;
        logic             fill;
    } cmd_t;

    // Limit a requested shift count to MAX_SHIFT
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : c;
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Control stage for the 4-bit universal shift register: accepts a command on
// a valid/ready handshake, parallel-loads the word, shifts it N times, then
// captures the register output and pulses done.
//
// Ports:
//   clk, clear                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_word, cmd_dir,
//   cmd_count, cmd_fill        command payload (dir 0 = right, 1 = left)
//   reg_q                      register feedback {A3,A2,A1,A0}
//   S0, S1                     register mode selects
//   par_out                    register parallel inputs I3..I0
//   shift_right, shift_left    register serial inputs (MSB side / LSB side)
//   busy, done, result         status and captured value
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_word,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] reg_q,
    output logic             S0,
    output logic             S1,
    output logic [WIDTH-1:0] par_out,
    output logic             shift_right,
    output logic             shift_left,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_d;
    logic             done_d;
    logic [1:0]       mode_d;
    logic [WIDTH-1:0] par_d;
    logic             shr_d, shl_d;
    logic             busy_d, ready_d;
    logic             ready_q;

    // Ready is suppressed while reset is asserted
    assign cmd_ready = ready_q & clear;

    // State, latched command, counter and registered outputs
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            S0          <= 1'b0;
            S1          <= 1'b0;
            par_out     <= '0;
            shift_right <= 1'b0;
            shift_left  <= 1'b0;
            busy        <= 1'b0;
            ready_q     <= 1'b1;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            S0          <= mode_d[1];
            S1          <= mode_d[0];
            par_out     <= par_d;
            shift_right <= shr_d;
            shift_left  <= shl_d;
            busy        <= busy_d;
            ready_q     <= ready_d;
            done        <= done_d;
            result      <= result_d;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        result_d = result;
        done_d   = 1'b0;
        mode_d   = MODE_HOLD;
        par_d    = '0;
        shr_d    = 1'b0;
        shl_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.word = cmd_word;
                    cmd_d.dir  = cmd_dir;
                    cmd_d.fill = cmd_fill;
                    cnt_d      = clamp_count(cmd_count);
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (cnt_q != '0) ? ST_SHIFT : ST_CAPTURE;
            end
            ST_SHIFT: begin
                // Entered only with cnt_q >= 1, so the decrement cannot wrap
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                result_d = reg_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it
        case (state_d)
            ST_LOAD: begin
                mode_d = MODE_LOAD;
                par_d  = cmd_d.word;
            end
            ST_SHIFT: begin
                if (cmd_d.dir) begin
                    mode_d = MODE_SHL;
                    shl_d  = cmd_d.fill;
                end else begin
                    mode_d = MODE_SHR;
                    shr_d  = cmd_d.fill;
                end
            end
            default: begin
                mode_d = MODE_HOLD;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench: sequencer driving a behavioural 4-bit universal shift register,
// closed through reg_q. Table-driven commands plus reset and back-to-back runs.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_word;
    logic       cmd_dir;
    logic [2:0] cmd_count;
    logic       cmd_fill;
    logic [3:0] reg_q;
    logic       S0, S1;
    logic [3:0] par_out;
    logic       shift_right, shift_left;
    logic       busy, done;
    logic [3:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk        (clk),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_word   (cmd_word),
        .cmd_dir    (cmd_dir),
        .cmd_count  (cmd_count),
        .cmd_fill   (cmd_fill),
        .reg_q      (reg_q),
        .S0         (S0),
        .S1         (S1),
        .par_out    (par_out),
        .shift_right(shift_right),
        .shift_left (shift_left),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    // Downstream universal shift register, {S0,S1}: 00 hold, 01 right, 10 left, 11 load
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            reg_q <= 4'b0000;
        end else begin
            case ({S0, S1})
                2'b01:   reg_q <= {shift_right, reg_q[3:1]};
                2'b10:   reg_q <= {reg_q[2:0], shift_left};
                2'b11:   reg_q <= par_out;
                default: reg_q <= reg_q;
            endcase
        end
    end

    typedef struct {
        string      name;
        logic [3:0] word;
        logic       dir;
        logic [2:0] count;
        logic       fill;
        logic [3:0] exp_result;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called after the acceptance edge; returns edges until done is seen
    task automatic wait_done(input string name, output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            check({name, "_busy"}, 32'(busy), 32'd1);
            check({name, "_ready_low"}, 32'(cmd_ready), 32'd0);
        end
        if (lat < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drive_cmd(input logic [3:0] w, input logic d, input logic [2:0] c, input logic f);
        cmd_valid = 1'b1;
        cmd_word  = w;
        cmd_dir   = d;
        cmd_count = c;
        cmd_fill  = f;
    endtask

    vec_t vecs[4];

    initial begin
        int lat;
        vecs[0] = '{"right2",  4'b1010, 1'b0, 3'd2, 1'b1, 4'b1110, 4};
        vecs[1] = '{"left3",   4'b1011, 1'b1, 3'd3, 1'b0, 4'b1000, 5};
        vecs[2] = '{"zero",    4'b0101, 1'b0, 3'd0, 1'b0, 4'b0101, 2};
        vecs[3] = '{"clamp7",  4'b0000, 1'b0, 3'd7, 1'b1, 4'b1111, 6};

        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_word  = '0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        cmd_fill  = 1'b0;
        #12;
        check("rst_S0S1", 32'({S0, S1}), 32'd0);
        check("rst_par_out", 32'(par_out), 32'd0);
        check("rst_serial", 32'({shift_right, shift_left}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ready_in_reset", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        #1;
        check("rst_ready_released", 32'(cmd_ready), 32'd1);

        // Table of single commands
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_cmd(vecs[i].word, vecs[i].dir, vecs[i].count, vecs[i].fill);
            check({vecs[i].name, "_ready"}, 32'(cmd_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_word  = ~vecs[i].word;
            cmd_fill  = ~vecs[i].fill;
            wait_done(vecs[i].name, lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].exp_result));
            check({vecs[i].name, "_ready_done"}, 32'(cmd_ready), 32'd1);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
            check({vecs[i].name, "_result_hold"}, 32'(result), 32'(vecs[i].exp_result));
        end

        // Register trace for the right-shift example
        @(negedge clk);
        drive_cmd(4'b1010, 1'b0, 3'd2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("trace_load", 32'(reg_q), 32'b1010);
        @(posedge clk); #1;
        check("trace_shift1", 32'(reg_q), 32'b1101);
        @(posedge clk); #1;
        check("trace_shift2", 32'(reg_q), 32'b1110);
        @(posedge clk); #1;
        check("trace_done", 32'(done), 32'd1);

        // Reset during the second SHIFT cycle
        @(negedge clk);
        drive_cmd(4'b1010, 1'b0, 3'd3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("midrst_in_shift", 32'({S0, S1}), 32'b01);
        clear = 1'b0;
        #1;
        check("midrst_S0S1", 32'({S0, S1}), 32'd0);
        check("midrst_par_serial", 32'({par_out, shift_right, shift_left}), 32'd0);
        check("midrst_busy_done", 32'({busy, done}), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            check("midrst_no_done", 32'({done, busy}), 32'd0);
        end
        @(negedge clk);
        drive_cmd(4'b1011, 1'b1, 3'd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done("post_rst", lat);
        check("post_rst_latency", 32'(lat), 32'd5);
        check("post_rst_result", 32'(result), 32'b1000);

        // Back-to-back with cmd_valid held across the first operation
        @(negedge clk);
        drive_cmd(4'b1010, 1'b0, 3'd2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_cmd(4'b1011, 1'b1, 3'd3, 1'b0);
        wait_done("b2b_first", lat);
        check("b2b_first_latency", 32'(lat), 32'd4);
        check("b2b_first_result", 32'(result), 32'b1110);
        check("b2b_ready_in_done", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check("b2b_accepted", 32'({busy, cmd_ready, done}), 32'b100);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_count = 3'd0;
        wait_done("b2b_second", lat);
        check("b2b_second_latency", 32'(lat), 32'd5);
        check("b2b_second_result", 32'(result), 32'b1000);
        @(posedge clk); #1;
        check("b2b_end_idle", 32'({busy, done, cmd_ready}), 32'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
